// File: rtl/proc_defs.sv
// rtl/proc_defs.sv - shared opcode constants, widths and fetch state encoding
package proc_defs;

   localparam int PC_W_DEF    = 12;
   localparam int INSTR_W_DEF = 32;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_BEQ   = 5'b01000;
   localparam logic [4:0] OP_BNE   = 5'b01001;
   localparam logic [4:0] OP_JMP   = 5'b01100;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HELD   = 2'd2,
      ST_BUBBLE = 2'd3
   } fetch_state_t;

   // Opcode lives in the top five bits of every instruction word
   function automatic logic [4:0] opcode_of(input logic [31:0] word);
      return word[31:27];
   endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - single-entry instruction+PC buffer with output mux
module fetch_hold_buf
   import proc_defs::*;
#(
   parameter int PC_W    = PC_W_DEF,
   parameter int INSTR_W = INSTR_W_DEF
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               load,
   input  logic               clear,
   input  logic               sel_hold,
   input  logic [INSTR_W-1:0] live_instr,
   input  logic [PC_W-1:0]    live_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc
);

   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [PC_W-1:0]    pc_q, pc_d;

   // Next buffer contents: load wins over clear, otherwise retain
   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      if (load) begin
         instr_d = live_instr;
         pc_d    = live_pc;
      end else if (clear) begin
         instr_d = '0;
         pc_d    = '0;
      end
   end

   // Buffer storage; reset drops whatever was held
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         instr_q <= '0;
         pc_q    <= '0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
      end
   end

   // Present either the held word or the live ROM word
   always_comb begin
      out_instr = sel_hold ? instr_q : live_instr;
      out_pc    = sel_hold ? pc_q    : live_pc;
   end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch sequencer driving a synchronous instruction ROM
module instr_fetch
   import proc_defs::*;
#(
   parameter int              PC_W     = PC_W_DEF,
   parameter int              INSTR_W  = INSTR_W_DEF,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic               clock,
   input  logic               reset_n,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               redirect,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    instr_pc,
   output logic [PC_W-1:0]    pc_plus1,
   output logic [4:0]         opcode
);

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] fpc_q, fpc_d;
   logic [PC_W-1:0] dpc_q, dpc_d;

   logic               valid_w;
   logic               accept_w;
   logic               hold_load;
   logic               hold_clear;
   logic [INSTR_W-1:0] sel_instr;
   logic [PC_W-1:0]    sel_pc;

   assign valid_w    = (state_q == ST_RUN) || (state_q == ST_HELD);
   assign accept_w   = valid_w && !stall;
   // Capture the live word only on the first stalled cycle; HELD keeps it
   assign hold_load  = (state_q == ST_RUN) && stall;
   assign hold_clear = accept_w && redirect;

   fetch_hold_buf #(
      .PC_W    (PC_W),
      .INSTR_W (INSTR_W)
   ) u_hold (
      .clock      (clock),
      .reset_n    (reset_n),
      .load       (hold_load),
      .clear      (hold_clear),
      .sel_hold   (state_q == ST_HELD),
      .live_instr (imem_rdata),
      .live_pc    (dpc_q),
      .out_instr  (sel_instr),
      .out_pc     (sel_pc)
   );

   // Next fetch state and PCs; fpc freezes while stalled so the ROM word
   // for fpc is still on imem_rdata when the stall releases
   always_comb begin
      state_d = state_q;
      fpc_d   = fpc_q;
      dpc_d   = dpc_q;
      case (state_q)
         ST_BOOT, ST_BUBBLE: begin
            state_d = ST_RUN;
            dpc_d   = fpc_q;
            fpc_d   = fpc_q + PC_W'(1);
         end
         ST_RUN, ST_HELD: begin
            if (stall) begin
               state_d = ST_HELD;
            end else if (redirect) begin
               state_d = ST_BUBBLE;
               fpc_d   = redirect_pc;
            end else begin
               state_d = ST_RUN;
               dpc_d   = fpc_q;
               fpc_d   = fpc_q + PC_W'(1);
            end
         end
         default: state_d = ST_BOOT;
      endcase
   end

   // State and PC registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_BOOT;
         fpc_q   <= RESET_PC;
         dpc_q   <= RESET_PC;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         dpc_q   <= dpc_d;
      end
   end

   // Decode-facing outputs; word forced to zero when nothing valid is shown
   always_comb begin
      imem_addr   = fpc_q;
      instr_valid = valid_w;
      instr       = valid_w ? sel_instr : '0;
      instr_pc    = sel_pc;
      pc_plus1    = sel_pc + PC_W'(1);
      opcode      = opcode_of(instr);
   end

endmodule
